// File: rtl/hazard_fwd_unit.sv
// Forwarding and interlock controller for the TinyRISC pipeline.
// A shift scoreboard of destination tags (slot 0 = EX ... slot DEPTH-1 = WB)
// drives per-operand forward selects, load-use stalls and branch flush windows.
module hazard_fwd_unit #(
   parameter int unsigned REG_W        = 4,
   parameter int unsigned DEPTH        = 3,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter bit          R0_ZERO      = 1'b0,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_valid,
   input  logic [REG_W-1:0] issue_rd,
   input  logic             issue_wb,
   input  logic             issue_is_load,
   input  logic [REG_W-1:0] issue_rs1,
   input  logic [REG_W-1:0] issue_rs2,
   input  logic             issue_use_rs1,
   input  logic             issue_use_rs2,
   input  logic             branch_taken,
   output logic [2:0]       fwd_sel_rs1,
   output logic [2:0]       fwd_sel_rs2,
   output logic             stall,
   output logic             flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic [DEPTH-1:0]            slot_valid_q;
   logic [DEPTH-1:0]            slot_wb_q;
   logic [DEPTH-1:0][REG_W-1:0] slot_rd_q;
   // Only slot 0 can cause a load-use stall, so the load flag is kept for it alone.
   logic                        slot0_load_q;
   logic [2:0]                  fc_q, fc_d;
   logic [CNT_W-1:0]            stall_cnt_q, flush_cnt_q;

   logic [DEPTH-1:0] match_rs1, match_rs2;
   logic             rs1_zero, rs2_zero;
   logic             load_use;
   logic             accept;

   // Per-slot match vectors for each source operand.
   always_comb begin
      rs1_zero  = R0_ZERO && (issue_rs1 == '0);
      rs2_zero  = R0_ZERO && (issue_rs2 == '0);
      match_rs1 = '0;
      match_rs2 = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         match_rs1[k] = issue_use_rs1 & slot_valid_q[k] & slot_wb_q[k] &
                        (slot_rd_q[k] == issue_rs1) & ~rs1_zero;
         match_rs2[k] = issue_use_rs2 & slot_valid_q[k] & slot_wb_q[k] &
                        (slot_rd_q[k] == issue_rs2) & ~rs2_zero;
      end
   end

   // Forward selects: scan oldest to youngest so the youngest match wins.
   always_comb begin
      fwd_sel_rs1 = '0;
      fwd_sel_rs2 = '0;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
         if (match_rs1[k]) fwd_sel_rs1 = 3'(k + 1);
         if (match_rs2[k]) fwd_sel_rs2 = 3'(k + 1);
      end
   end

   // Hazard decode: flush has priority over a load-use stall.
   always_comb begin
      load_use = issue_valid & slot0_load_q & (match_rs1[0] | match_rs2[0]);
      flush    = branch_taken | (fc_q != 3'd0);
      stall    = load_use & ~flush;
      accept   = issue_valid & ~stall & ~flush;
      if (branch_taken) begin
         fc_d = 3'(FLUSH_CYCLES - 1);
      end else if (fc_q != 3'd0) begin
         fc_d = fc_q - 3'd1;
      end else begin
         fc_d = fc_q;
      end
   end

   // Scoreboard shift: slot 0 takes the issue fields or a bubble; the last slot retires.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_valid_q <= '0;
         slot_wb_q    <= '0;
         slot_rd_q    <= '0;
         slot0_load_q <= 1'b0;
      end else begin
         slot_valid_q <= {slot_valid_q[DEPTH-2:0], accept};
         slot_wb_q    <= {slot_wb_q[DEPTH-2:0], issue_wb};
         slot_rd_q    <= {slot_rd_q[DEPTH-2:0], issue_rd};
         slot0_load_q <= issue_is_load;
      end
   end

   // Flush down-counter and saturating statistics counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fc_q        <= 3'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         fc_q <= fc_d;
         if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
         if (branch_taken && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: forwarding priority, load-use stall,
// flush windows, R0 handling (two instances) and asynchronous reset.
module tb_hazard_fwd_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid, issue_wb, issue_is_load;
   logic [3:0]  issue_rd, issue_rs1, issue_rs2;
   logic        issue_use_rs1, issue_use_rs2, branch_taken;

   logic [2:0]  fwd1, fwd2, fwd1_z, fwd2_z;
   logic        stall, flush, stall_z, flush_z;
   logic [15:0] stall_cnt, flush_cnt, stall_cnt_z, flush_cnt_z;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   hazard_fwd_unit #(.REG_W(4), .DEPTH(3), .FLUSH_CYCLES(2), .R0_ZERO(1'b0), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
      .issue_wb(issue_wb), .issue_is_load(issue_is_load), .issue_rs1(issue_rs1),
      .issue_rs2(issue_rs2), .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
      .branch_taken(branch_taken), .fwd_sel_rs1(fwd1), .fwd_sel_rs2(fwd2), .stall(stall),
      .flush(flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   hazard_fwd_unit #(.REG_W(4), .DEPTH(3), .FLUSH_CYCLES(2), .R0_ZERO(1'b1), .CNT_W(16)) dut_z (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
      .issue_wb(issue_wb), .issue_is_load(issue_is_load), .issue_rs1(issue_rs1),
      .issue_rs2(issue_rs2), .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
      .branch_taken(branch_taken), .fwd_sel_rs1(fwd1_z), .fwd_sel_rs2(fwd2_z), .stall(stall_z),
      .flush(flush_z), .stall_cnt(stall_cnt_z), .flush_cnt(flush_cnt_z)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Drive one OF-stage instruction plus branch_taken, then let logic settle.
   task automatic drive(input logic v, input logic [3:0] rd, input logic wb, input logic ld,
                        input logic [3:0] rs1, input logic u1, input logic [3:0] rs2,
                        input logic u2, input logic br);
      issue_valid   = v;
      issue_rd      = rd;
      issue_wb      = wb;
      issue_is_load = ld;
      issue_rs1     = rs1;
      issue_use_rs1 = u1;
      issue_rs2     = rs2;
      issue_use_rs2 = u2;
      branch_taken  = br;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      check_eq("rst_fwd1", fwd1, 0);
      check_eq("rst_stall", stall, 0);
      check_eq("rst_flush", flush, 0);
      check_eq("rst_stall_cnt", stall_cnt, 0);
      check_eq("rst_flush_cnt", flush_cnt, 0);
      @(posedge clk);
      #2 rst = 1'b1;

      // r3 <- (r1, r2) with an empty scoreboard
      drive(1, 3, 1, 0, 1, 1, 2, 1, 0);
      check_eq("empty_fwd1", fwd1, 0);
      check_eq("empty_fwd2", fwd2, 0);
      check_eq("empty_stall", stall, 0);
      check_eq("empty_flush", flush, 0);
      tick();
      // r5 writer
      drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
      tick();
      // r6 <- r5 : slot 0
      drive(1, 6, 1, 0, 5, 1, 0, 0, 0);
      check_eq("alu_b2b_fwd1", fwd1, 1);
      tick();
      // r5 <- r5 : old r5 now in slot 1
      drive(1, 5, 1, 0, 5, 1, 0, 0, 0);
      check_eq("alu_gap_fwd1", fwd1, 2);
      tick();
      // slots: r5(new), r6, r5(old) -> youngest r5 wins
      drive(1, 8, 1, 0, 5, 1, 6, 1, 0);
      check_eq("prio_fwd1", fwd1, 1);
      check_eq("prio_fwd2", fwd2, 2);
      tick();

      // load r4 then a reader of r4 on rs2
      drive(1, 4, 1, 1, 0, 0, 0, 0, 0);
      check_eq("load_issue_stall", stall, 0);
      tick();
      drive(1, 9, 1, 0, 1, 1, 4, 1, 0);
      check_eq("lu_stall", stall, 1);
      check_eq("lu_fwd2", fwd2, 1);
      tick();
      check_eq("lu_stall_cnt", stall_cnt, 1);
      check_eq("lu_retry_stall", stall, 0);
      check_eq("lu_retry_fwd2", fwd2, 2);
      tick();
      check_eq("lu_after_stall_cnt", stall_cnt, 1);

      // taken branch: two flush cycles, squashed writer never lands
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      check_eq("br_flush_c1", flush, 1);
      tick();
      check_eq("br_flush_cnt1", flush_cnt, 1);
      drive(1, 10, 1, 0, 0, 0, 0, 0, 0);
      check_eq("br_flush_c2", flush, 1);
      check_eq("br_c2_stall", stall, 0);
      tick();
      drive(1, 11, 0, 0, 10, 1, 0, 0, 0);
      check_eq("br_flush_c3", flush, 0);
      check_eq("br_squashed_fwd1", fwd1, 0);
      tick();

      // back-to-back branches extend the window
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      check_eq("br2_flush_a", flush, 1);
      tick();
      check_eq("br2_flush_cnt_a", flush_cnt, 2);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      check_eq("br2_flush_b", flush, 1);
      tick();
      check_eq("br2_flush_cnt_b", flush_cnt, 3);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_eq("br2_flush_tail", flush, 1);
      tick();
      check_eq("br2_flush_end", flush, 0);

      // flush beats stall
      drive(1, 11, 1, 1, 0, 0, 0, 0, 0);
      tick();
      drive(0, 12, 1, 0, 11, 1, 0, 0, 0);
      check_eq("novalid_stall", stall, 0);
      drive(1, 12, 1, 0, 11, 1, 0, 0, 1);
      check_eq("fbs_stall", stall, 0);
      check_eq("fbs_flush", flush, 1);
      tick();
      check_eq("fbs_stall_cnt", stall_cnt, 1);
      check_eq("fbs_flush_cnt", flush_cnt, 4);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      check_eq("fbs_flush_end", flush, 0);

      // writer (load) to r0 then reader of r0 on both instances
      drive(1, 0, 1, 1, 0, 0, 0, 0, 0);
      tick();
      drive(1, 7, 1, 0, 0, 1, 0, 1, 0);
      check_eq("r0_fwd1", fwd1, 1);
      check_eq("r0_stall", stall, 1);
      check_eq("r0z_fwd1", fwd1_z, 0);
      check_eq("r0z_fwd2", fwd2_z, 0);
      check_eq("r0z_stall", stall_z, 0);
      tick();
      check_eq("r0_stall_cnt", stall_cnt, 2);

      // reset in the middle of a flush window
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_eq("pre_rst_flush", flush, 1);
      rst = 1'b0;
      #1;
      check_eq("midrst_flush", flush, 0);
      check_eq("midrst_stall_cnt", stall_cnt, 0);
      check_eq("midrst_flush_cnt", flush_cnt, 0);
      #1 rst = 1'b1;
      drive(1, 2, 1, 0, 7, 1, 0, 1, 0);
      check_eq("post_rst_fwd1", fwd1, 0);
      check_eq("post_rst_fwd2", fwd2, 0);
      check_eq("post_rst_flush", flush, 0);
      tick();
      check_eq("post_rst_flush2", flush, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
